npc_seq_ctrl: RTL and testbench

- Multi-cycle instruction sequencer for the NPC core.
- Fetches each instruction over a valid/ready instruction-memory handshake and decodes it.
- Feeds the combinational execute unit (op, funct3, imm, src1) and captures its result.
- Writes the result back to the register file, advances the PC and halts on ebreak, illegal instruction or fetch timeout.

---
 rtl/npc_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_npc_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : npc_seq_ctrl
// Purpose  : Multi-cycle instruction sequencer for the NPC core. Fetches one
//            instruction at a time over a valid/ready instruction-memory
//            handshake, decodes it (addi and ebreak only), drives the
//            combinational execute unit, captures its result and writes it
//            back to the register file, then advances the PC. Any ebreak,
//            unsupported encoding or fetch timeout parks the core in HALT
//            until reset.
//
// Ports    : clk, rst_n          - clock (rising edge) / async active-low reset
//            imem_req_valid_o   - fetch request valid (FETCH_REQ only)
//            imem_req_ready_i   - memory accepts the request
//            imem_addr_o        - fetch address, always equal to pc
//            imem_rsp_valid_i   - fetched word valid
//            imem_rsp_data_i    - fetched instruction word
//            rs1_addr_o         - regfile read address from the latched inst
//            rf_rdata1_i        - regfile read data (combinational)
//            ex_op_o/funct3_o/imm_o/src1_o - operands to the execute unit
//            ex_result_i        - execute unit result (combinational)
//            rf_wen_o/waddr_o/wdata_o      - regfile write port
//            pc_o, instret_o    - current PC / retired-instruction count
//            halt_o, illegal_o, fetch_err_o - sticky termination causes
//
// Revision : 1.0 - initial release
// ============================================================================
module npc_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          TIMEOUT_CYC = 16,
  parameter int          TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  // register file read
  output logic [4:0]  rs1_addr_o,
  input  logic [31:0] rf_rdata1_i,
  // execute unit
  output logic [6:0]  ex_op_o,
  output logic [2:0]  ex_funct3_o,
  output logic [11:0] ex_imm_o,
  output logic [31:0] ex_src1_o,
  input  logic [31:0] ex_result_i,
  // register file write
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  // status
  output logic [31:0] pc_o,
  output logic [31:0] instret_o,
  output logic        halt_o,
  output logic        illegal_o,
  output logic        fetch_err_o
);

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXEC       = 3'd3,
    ST_WB         = 3'd4,
    ST_HALT       = 3'd5
  } state_e;

  localparam logic [31:0]     c_ebreak  = 32'h0010_0073;
  localparam logic [6:0]      c_op_imm  = 7'b0010011;
  localparam logic [2:0]      c_f3_addi = 3'b000;
  // Last counter value seen in FETCH_WAIT before giving up on the response.
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       instret_q;
  logic [31:0]       inst_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [6:0]        ex_op_q;
  logic [2:0]        ex_funct3_q;
  logic [11:0]       ex_imm_q;
  logic [31:0]       ex_src1_q;
  logic [4:0]        rd_q;
  logic [31:0]       wb_data_q;
  logic              rf_wen_q;
  logic              halt_q;
  logic              illegal_q;
  logic              fetch_err_q;

  logic [31:0]       pc_d;
  logic [31:0]       instret_d;
  logic [TO_W-1:0]   to_cnt_d;
  logic              w_is_addi;

  // Both counters wrap naturally at 2^32.
  assign pc_d      = pc_q + 32'd4;
  assign instret_d = instret_q + 32'd1;
  assign to_cnt_d  = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
  assign w_is_addi = (inst_q[6:0] == c_op_imm) && (inst_q[14:12] == c_f3_addi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH_REQ;
      pc_q        <= RESET_PC;
      instret_q   <= '0;
      inst_q      <= '0;
      to_cnt_q    <= '0;
      ex_op_q     <= '0;
      ex_funct3_q <= '0;
      ex_imm_q    <= '0;
      ex_src1_q   <= '0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      rf_wen_q    <= 1'b0;
      halt_q      <= 1'b0;
      illegal_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      case (state_q)
        // No timeout while the memory refuses the request; the response
        // input is deliberately ignored here.
        ST_FETCH_REQ: begin
          if (imem_req_ready_i) begin
            to_cnt_q <= '0;
            state_q  <= ST_FETCH_WAIT;
          end
        end

        // A response in the timeout cycle is still accepted.
        ST_FETCH_WAIT: begin
          if (imem_rsp_valid_i) begin
            inst_q  <= imem_rsp_data_i;
            state_q <= ST_DECODE;
          end else if (to_cnt_q == c_to_last) begin
            fetch_err_q <= 1'b1;
            state_q     <= ST_HALT;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end

        ST_DECODE: begin
          if (inst_q == c_ebreak) begin
            halt_q  <= 1'b1;
            state_q <= ST_HALT;
          end else if (w_is_addi) begin
            ex_op_q     <= inst_q[6:0];
            ex_funct3_q <= inst_q[14:12];
            ex_imm_q    <= inst_q[31:20];
            ex_src1_q   <= rf_rdata1_i;
            rd_q        <= inst_q[11:7];
            state_q     <= ST_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= ST_HALT;
          end
        end

        // Write enable is registered here so it is high for exactly the WB
        // cycle; writes to x0 are suppressed.
        ST_EXEC: begin
          wb_data_q <= ex_result_i;
          rf_wen_q  <= (rd_q != 5'd0);
          state_q   <= ST_WB;
        end

        ST_WB: begin
          rf_wen_q  <= 1'b0;
          pc_q      <= pc_d;
          instret_q <= instret_d;
          state_q   <= ST_FETCH_REQ;
        end

        ST_HALT: begin
          state_q <= ST_HALT;
        end

        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req_valid_o = (state_q == ST_FETCH_REQ);
  assign imem_addr_o      = pc_q;
  assign rs1_addr_o       = inst_q[19:15];

  assign ex_op_o          = ex_op_q;
  assign ex_funct3_o      = ex_funct3_q;
  assign ex_imm_o         = ex_imm_q;
  assign ex_src1_o        = ex_src1_q;

  assign rf_wen_o         = rf_wen_q;
  assign rf_waddr_o       = rd_q;
  assign rf_wdata_o       = wb_data_q;

  assign pc_o             = pc_q;
  assign instret_o        = instret_q;
  assign halt_o           = halt_q;
  assign illegal_o        = illegal_q;
  assign fetch_err_o      = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_npc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_seq_ctrl
// Purpose  : Directed self-checking bench for npc_seq_ctrl. A second instance
//            with RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks   = 0;
  int          failures = 0;

  // ---------------- primary DUT ----------------
  logic        req_valid, req_ready, rsp_valid;
  logic [31:0] addr, rsp_data, rdata1, src1, result, wdata, pc, instret;
  logic [4:0]  rs1, waddr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [11:0] imm;
  logic        wen, halt, illegal, ferr;
  logic [31:0] regs [32];

  // ---------------- wrap DUT ----------------
  logic        req_valid2, req_ready2, rsp_valid2;
  logic [31:0] addr2, rsp_data2, src1_2, result2, wdata2, pc2, instret2;
  logic [4:0]  rs1_2, waddr2;
  logic [6:0]  op2;
  logic [2:0]  f3_2;
  logic [11:0] imm2;
  logic        wen2, halt2, illegal2, ferr2;

  always #5 clk = ~clk;

  // Execute unit and regfile models (addi only).
  assign result  = src1 + {{20{imm[11]}}, imm};
  assign result2 = src1_2 + {{20{imm2[11]}}, imm2};
  assign rdata1  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  always @(posedge clk) if (wen) regs[waddr] <= wdata;

  npc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_addr_o(addr), .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .rs1_addr_o(rs1), .rf_rdata1_i(rdata1),
    .ex_op_o(op), .ex_funct3_o(f3), .ex_imm_o(imm), .ex_src1_o(src1),
    .ex_result_i(result),
    .rf_wen_o(wen), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .pc_o(pc), .instret_o(instret),
    .halt_o(halt), .illegal_o(illegal), .fetch_err_o(ferr)
  );

  npc_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid_o(req_valid2), .imem_req_ready_i(req_ready2),
    .imem_addr_o(addr2), .imem_rsp_valid_i(rsp_valid2), .imem_rsp_data_i(rsp_data2),
    .rs1_addr_o(rs1_2), .rf_rdata1_i(32'd0),
    .ex_op_o(op2), .ex_funct3_o(f3_2), .ex_imm_o(imm2), .ex_src1_o(src1_2),
    .ex_result_i(result2),
    .rf_wen_o(wen2), .rf_waddr_o(waddr2), .rf_wdata_o(wdata2),
    .pc_o(pc2), .instret_o(instret2),
    .halt_o(halt2), .illegal_o(illegal2), .fetch_err_o(ferr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_ready2 = 1'b0; rsp_valid2 = 1'b0; rsp_data2 = '0;
    do_reset();
    checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=80000000", pc); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if ({halt, illegal, ferr} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {halt, illegal, ferr}); end
    checks++; if (req_valid !== 1'b1 || wen !== 1'b0) begin failures++; $display("FAIL reset_valid_wen got=%b%b exp=10", req_valid, wen); end
    checks++; if (imm !== 12'd0 || wdata !== 32'd0) begin failures++; $display("FAIL reset_ex_wb got=%h/%h exp=0/0", imm, wdata); end
  endtask

  // One addi with zero-wait memory; entered and left in FETCH_REQ.
  task automatic run_addi(input logic [31:0] word, input logic [31:0] exp_addr,
                          input logic [31:0] exp_src1, input logic [11:0] exp_imm,
                          input logic exp_wen, input logic [4:0] exp_rd,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_pc,
                          input logic [31:0] exp_ir, input string name);
    checks++; if (req_valid !== 1'b1 || addr !== exp_addr) begin failures++; $display("FAIL %s_req got=%b/%h exp=1/%h", name, req_valid, addr, exp_addr); end
    req_ready = 1'b1;
    tick();                                   // -> FETCH_WAIT
    req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL %s_wait_valid got=%b exp=0", name, req_valid); end
    rsp_valid = 1'b1; rsp_data = word;
    tick();                                   // -> DECODE
    rsp_valid = 1'b0; rsp_data = '0;
    checks++; if (rs1 !== word[19:15]) begin failures++; $display("FAIL %s_rs1 got=%0d exp=%0d", name, rs1, word[19:15]); end
    tick();                                   // -> EXEC
    checks++; if (op !== 7'h13 || f3 !== 3'd0 || imm !== exp_imm || src1 !== exp_src1) begin
      failures++; $display("FAIL %s_ex got=%h/%0d/%h/%h exp=13/0/%h/%h", name, op, f3, imm, src1, exp_imm, exp_src1); end
    tick();                                   // -> WB
    checks++; if (wen !== exp_wen || waddr !== exp_rd || wdata !== exp_wdata || pc !== exp_addr) begin
      failures++; $display("FAIL %s_wb got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", name, wen, waddr, wdata, pc, exp_wen, exp_rd, exp_wdata, exp_addr); end
    tick();                                   // -> FETCH_REQ
    checks++; if (wen !== 1'b0 || pc !== exp_pc || instret !== exp_ir || req_valid !== 1'b1) begin
      failures++; $display("FAIL %s_retire got=%b/%h/%0d/%b exp=0/%h/%0d/1", name, wen, pc, instret, req_valid, exp_pc, exp_ir); end
  endtask

  task automatic test_addi();
    run_addi(32'h0050_0093, 32'h8000_0000, 32'd0, 12'd5, 1'b1, 5'd1, 32'd5, 32'h8000_0004, 32'd1, "addi_x1");
  endtask

  task automatic test_addi_x0();
    run_addi(32'h0070_0013, 32'h8000_0004, 32'd0, 12'd7, 1'b0, 5'd0, 32'd7, 32'h8000_0008, 32'd2, "addi_x0");
  endtask

  task automatic test_ebreak();
    checks++; if (addr !== 32'h8000_0008) begin failures++; $display("FAIL ebreak_addr got=%h exp=80000008", addr); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0010_0073;
    tick();                                   // -> DECODE
    rsp_valid = 1'b0;
    tick();                                   // -> HALT
    checks++; if ({halt, illegal, ferr} !== 3'b100) begin failures++; $display("FAIL ebreak_flags got=%b exp=100", {halt, illegal, ferr}); end
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (req_valid !== 1'b0 || wen !== 1'b0) begin failures++; $display("FAIL ebreak_hold%0d got=%b%b exp=00", i, req_valid, wen); end
    end
    req_ready = 1'b0; rsp_valid = 1'b0;
    checks++; if (pc !== 32'h8000_0008 || instret !== 32'd2 || {halt, illegal, ferr} !== 3'b100) begin
      failures++; $display("FAIL ebreak_frozen got=%h/%0d/%b exp=80000008/2/100", pc, instret, {halt, illegal, ferr}); end
  endtask

  task automatic test_backpressure_timeout();
    do_reset();
    // Response strobes while the request is not yet accepted must be ignored.
    rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (req_valid !== 1'b1 || ferr !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%b%b exp=10", i, req_valid, ferr); end
    end
    rsp_valid = 1'b0;
    checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL bp_pc got=%h exp=80000000", pc); end
    req_ready = 1'b1;
    tick();                                   // -> FETCH_WAIT
    req_ready = 1'b0;
    repeat (15) tick();
    checks++; if (ferr !== 1'b0 || req_valid !== 1'b0) begin failures++; $display("FAIL to_early got=%b%b exp=00", ferr, req_valid); end
    tick();
    checks++; if ({halt, illegal, ferr} !== 3'b001) begin failures++; $display("FAIL to_flags got=%b exp=001", {halt, illegal, ferr}); end
    checks++; if (pc !== 32'h8000_0000 || instret !== 32'd0 || req_valid !== 1'b0) begin
      failures++; $display("FAIL to_state got=%h/%0d/%b exp=80000000/0/0", pc, instret, req_valid); end
  endtask

  // Response arriving in the last allowed cycle beats the timeout.
  task automatic test_rsp_wins();
    do_reset();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    repeat (15) tick();
    rsp_valid = 1'b1; rsp_data = 32'hFFD0_8113;     // addi x2, x1, -3
    tick();                                   // -> DECODE
    rsp_valid = 1'b0; rsp_data = '0;
    checks++; if ({halt, illegal, ferr} !== 3'b000) begin failures++; $display("FAIL win_flags got=%b exp=000", {halt, illegal, ferr}); end
    tick();                                   // -> EXEC
    checks++; if (src1 !== 32'd5 || imm !== 12'hFFD) begin failures++; $display("FAIL win_ex got=%h/%h exp=00000005/ffd", src1, imm); end
    tick();                                   // -> WB
    checks++; if (wen !== 1'b1 || waddr !== 5'd2 || wdata !== 32'd2) begin failures++; $display("FAIL win_wb got=%b/%0d/%h exp=1/2/00000002", wen, waddr, wdata); end
    tick();
    checks++; if (pc !== 32'h8000_0004 || instret !== 32'd1) begin failures++; $display("FAIL win_retire got=%h/%0d exp=80000004/1", pc, instret); end
  endtask

  task automatic check_illegal(input logic [31:0] word, input string name);
    do_reset();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = word;
    tick();                                   // -> DECODE
    rsp_valid = 1'b0; rsp_data = '0;
    tick();                                   // -> HALT
    checks++; if ({halt, illegal, ferr} !== 3'b010) begin failures++; $display("FAIL %s_flags got=%b exp=010", name, {halt, illegal, ferr}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wen !== 1'b0 || req_valid !== 1'b0) begin failures++; $display("FAIL %s_hold%0d got=%b%b exp=00", name, i, wen, req_valid); end
    end
    checks++; if (pc !== 32'h8000_0000 || instret !== 32'd0) begin failures++; $display("FAIL %s_frozen got=%h/%0d exp=80000000/0", name, pc, instret); end
  endtask

  task automatic test_illegal_and_midreset();
    check_illegal(32'h0000_0033, "ill_r");
    check_illegal(32'h0050_1093, "ill_f3");
    do_reset();
    run_addi(32'h0050_0093, 32'h8000_0000, 32'd0, 12'd5, 1'b1, 5'd1, 32'd5, 32'h8000_0004, 32'd1, "pre_rst");
    req_ready = 1'b1;
    tick();                                   // -> FETCH_WAIT
    req_ready = 1'b0;
    tick();
    rst_n = 1'b0;                             // asynchronous, between edges
    #1;
    checks++; if (pc !== 32'h8000_0000 || instret !== 32'd0 || {halt, illegal, ferr} !== 3'b000) begin
      failures++; $display("FAIL midrst_state got=%h/%0d/%b exp=80000000/0/000", pc, instret, {halt, illegal, ferr}); end
    checks++; if (req_valid !== 1'b1 || wen !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b%b exp=10", req_valid, wen); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_pc_wrap();
    checks++; if (pc2 !== 32'hFFFF_FFFC || req_valid2 !== 1'b1) begin failures++; $display("FAIL wrap_start got=%h/%b exp=fffffffc/1", pc2, req_valid2); end
    req_ready2 = 1'b1;
    tick();
    req_ready2 = 1'b0; rsp_valid2 = 1'b1; rsp_data2 = 32'h0010_0193;   // addi x3, x0, 1
    tick();
    rsp_valid2 = 1'b0;
    tick();                                   // -> EXEC
    tick();                                   // -> WB
    checks++; if (wen2 !== 1'b1 || waddr2 !== 5'd3 || wdata2 !== 32'd1) begin failures++; $display("FAIL wrap_wb got=%b/%0d/%h exp=1/3/00000001", wen2, waddr2, wdata2); end
    tick();
    checks++; if (pc2 !== 32'h0000_0000 || instret2 !== 32'd1 || addr2 !== 32'd0) begin
      failures++; $display("FAIL wrap_pc got=%h/%0d/%h exp=00000000/1/00000000", pc2, instret2, addr2); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_addi();
    test_addi_x0();
    test_ebreak();
    test_backpressure_timeout();
    test_rsp_wins();
    test_illegal_and_midreset();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
